// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the FIFO write arbiter: FSM states and source identifiers.
package myPkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        SEND_HI
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_RD,
        SRC_STS
    } src_t;

    localparam int unsigned NUM_SRC = 3;

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb3.sv
// Three-way round-robin arbiter: the search starts at the pointer and wraps upward;
// once a grant is taken, the pointer moves to the source after the winner.
module rr_arb3 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] req_i,
    input  logic       take_i,
    output logic [2:0] gnt_o
);

    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        unique case (ptr_q)
            2'd1:    gnt_o = req_i[1] ? 3'b010 : req_i[2] ? 3'b100 : req_i[0] ? 3'b001 : 3'b000;
            2'd2:    gnt_o = req_i[2] ? 3'b100 : req_i[0] ? 3'b001 : req_i[1] ? 3'b010 : 3'b000;
            default: gnt_o = req_i[0] ? 3'b001 : req_i[1] ? 3'b010 : req_i[2] ? 3'b100 : 3'b000;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (take_i) begin
            if (gnt_o[0]) begin
                ptr_d = 2'd1;
            end else if (gnt_o[1]) begin
                ptr_d = 2'd2;
            end else if (gnt_o[2]) begin
                ptr_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Merges ALU results (two bytes), register reads and status bytes into one FIFO write port.
// Each source has a single holding slot; the ALU pair is always written back to back.
module fifo_wr_arbiter
    import myPkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ALU_OUT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [ALU_OUT_WIDTH-1:0] i_alu_out,
    input  logic                     i_alu_valid,
    input  logic [DATA_WIDTH-1:0]    i_rd_data,
    input  logic                     i_rd_valid,
    input  logic [DATA_WIDTH-1:0]    i_sts_data,
    input  logic                     i_sts_valid,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]    o_fifo_wr_data,
    output logic                     o_busy,
    output logic                     o_drop
);

    arb_state_t               state_q, state_d;
    logic [NUM_SRC-1:0]       pend_q, pend_d;
    logic [ALU_OUT_WIDTH-1:0] alu_slot_q, alu_slot_d;
    logic [DATA_WIDTH-1:0]    rd_slot_q, rd_slot_d;
    logic [DATA_WIDTH-1:0]    sts_slot_q, sts_slot_d;
    logic [DATA_WIDTH-1:0]    hi_q, hi_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                     cur_alu_q, cur_alu_d;
    logic                     drop_q, drop_d;

    logic                     take;
    logic                     granted;
    logic [NUM_SRC-1:0]       gnt;
    logic [NUM_SRC-1:0]       gnt_mask;
    logic [NUM_SRC-1:0]       valid;

    rr_arb3 u_rr_arb3 (
        .clk_i  (i_clk),
        .rst_ni (i_reset),
        .req_i  (pend_q),
        .take_i (take),
        .gnt_o  (gnt)
    );

    assign o_fifo_wr_en   = (state_q != IDLE) && !i_fifo_full;
    assign o_fifo_wr_data = wr_data_q;
    assign o_busy         = (state_q != IDLE) || (|pend_q);
    assign o_drop         = drop_q;

    assign granted  = take && (|pend_q);
    assign gnt_mask = granted ? gnt : '0;
    assign valid    = {i_sts_valid, i_rd_valid, i_alu_valid};

    always_comb begin
        state_d   = state_q;
        wr_data_d = wr_data_q;
        hi_d      = hi_q;
        cur_alu_d = cur_alu_q;
        take      = 1'b0;
        unique case (state_q)
            IDLE: begin
                take = 1'b1;
            end
            SEND: begin
                if (o_fifo_wr_en) begin
                    if (cur_alu_q) begin
                        state_d   = SEND_HI;
                        wr_data_d = hi_q;
                    end else begin
                        take    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            SEND_HI: begin
                if (o_fifo_wr_en) begin
                    take    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh grant overrides the fall-back to IDLE chosen above.
        if (granted) begin
            state_d   = SEND;
            cur_alu_d = gnt[SRC_ALU];
            if (gnt[SRC_ALU]) begin
                wr_data_d = alu_slot_q[DATA_WIDTH-1:0];
                hi_d      = alu_slot_q[2*DATA_WIDTH-1:DATA_WIDTH];
            end else if (gnt[SRC_RD]) begin
                wr_data_d = rd_slot_q;
            end else begin
                wr_data_d = sts_slot_q;
            end
        end
    end

    // A slot still pending after this edge's grant cannot accept a new valid.
    always_comb begin
        pend_d     = pend_q & ~gnt_mask;
        alu_slot_d = alu_slot_q;
        rd_slot_d  = rd_slot_q;
        sts_slot_d = sts_slot_q;
        drop_d     = 1'b0;
        if (valid[SRC_ALU]) begin
            if (pend_d[SRC_ALU]) begin
                drop_d = 1'b1;
            end else begin
                pend_d[SRC_ALU] = 1'b1;
                alu_slot_d      = i_alu_out;
            end
        end
        if (valid[SRC_RD]) begin
            if (pend_d[SRC_RD]) begin
                drop_d = 1'b1;
            end else begin
                pend_d[SRC_RD] = 1'b1;
                rd_slot_d      = i_rd_data;
            end
        end
        if (valid[SRC_STS]) begin
            if (pend_d[SRC_STS]) begin
                drop_d = 1'b1;
            end else begin
                pend_d[SRC_STS] = 1'b1;
                sts_slot_d      = i_sts_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            alu_slot_q <= '0;
            rd_slot_q  <= '0;
            sts_slot_q <= '0;
            hi_q       <= '0;
            wr_data_q  <= '0;
            cur_alu_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            alu_slot_q <= alu_slot_d;
            rd_slot_q  <= rd_slot_d;
            sts_slot_q <= sts_slot_d;
            hi_q       <= hi_d;
            wr_data_q  <= wr_data_d;
            cur_alu_q  <= cur_alu_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// each cycle compared against a byte-queue reference model.
module tb_fifo_wr_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic [15:0] i_alu_out;
    logic        i_alu_valid;
    logic [7:0]  i_rd_data;
    logic        i_rd_valid;
    logic [7:0]  i_sts_data;
    logic        i_sts_valid;
    logic        i_fifo_full;
    logic        o_fifo_wr_en;
    logic [7:0]  o_fifo_wr_data;
    logic        o_busy;
    logic        o_drop;

    fifo_wr_arbiter #(
        .DATA_WIDTH    (8),
        .ALU_OUT_WIDTH (16)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_alu_out      (i_alu_out),
        .i_alu_valid    (i_alu_valid),
        .i_rd_data      (i_rd_data),
        .i_rd_valid     (i_rd_valid),
        .i_sts_data     (i_sts_data),
        .i_sts_valid    (i_sts_valid),
        .i_fifo_full    (i_fifo_full),
        .o_fifo_wr_en   (o_fifo_wr_en),
        .o_fifo_wr_data (o_fifo_wr_data),
        .o_busy         (o_busy),
        .o_drop         (o_drop)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bytes of the frame in flight, per-source slots, pointer.
    logic [7:0]  m_frame[$];
    logic [7:0]  m_last;
    logic [2:0]  m_pend;
    logic [15:0] m_alu;
    logic [7:0]  m_rd;
    logic [7:0]  m_sts;
    int          m_ptr;
    logic        m_drop;
    logic [7:0]  wr_log[$];

    logic [10:0] exp_vec;
    logic [10:0] dut_vec;
    assign dut_vec = {o_fifo_wr_en, o_fifo_wr_data, o_busy, o_drop};

    task automatic model_reset();
        m_frame.delete();
        m_last = 8'h00;
        m_pend = 3'b000;
        m_ptr  = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] v;
        bit         found;
        if (m_frame.size() > 0 && !i_fifo_full) void'(m_frame.pop_front());
        if (m_frame.size() == 0) begin
            found = 0;
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (m_ptr + k) % 3;
                if (!found && m_pend[s]) begin
                    found     = 1;
                    m_pend[s] = 1'b0;
                    m_ptr     = (s + 1) % 3;
                    if (s == 0) begin
                        m_frame.push_back(m_alu[7:0]);
                        m_frame.push_back(m_alu[15:8]);
                    end else if (s == 1) begin
                        m_frame.push_back(m_rd);
                    end else begin
                        m_frame.push_back(m_sts);
                    end
                end
            end
        end
        v      = {i_sts_valid, i_rd_valid, i_alu_valid};
        m_drop = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (v[s]) begin
                if (m_pend[s]) begin
                    m_drop = 1'b1;
                end else begin
                    m_pend[s] = 1'b1;
                    if (s == 0) m_alu = i_alu_out;
                    else if (s == 1) m_rd = i_rd_data;
                    else m_sts = i_sts_data;
                end
            end
        end
        if (m_frame.size() > 0) m_last = m_frame[0];
    endtask

    task automatic drive(input logic av, input logic [15:0] ad, input logic rv,
                         input logic [7:0] rdd, input logic sv, input logic [7:0] sd,
                         input logic full);
        i_alu_valid = av;
        i_alu_out   = ad;
        i_rd_valid  = rv;
        i_rd_data   = rdd;
        i_sts_valid = sv;
        i_sts_data  = sd;
        i_fifo_full = full;
        #1;
        exp_vec = {(m_frame.size() > 0) && !full, m_last,
                   (m_frame.size() > 0) || (|m_pend), m_drop};
    endtask

    task automatic advance();
        if (o_fifo_wr_en) wr_log.push_back(o_fifo_wr_data);
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        model_reset();
        wr_log.delete();
        i_reset = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        drive(1, 16'hFFFF, 1, 8'hFF, 1, 8'hFF, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        n_cmp++;
        if (o_fifo_wr_en !== 1'b0) begin
            n_err++; $display("FAIL reset_wr_en: got %b want 0", o_fifo_wr_en);
        end
        n_cmp++;
        if (o_fifo_wr_data !== 8'h00) begin
            n_err++; $display("FAIL reset_wr_data: got %h want 00", o_fifo_wr_data);
        end
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", o_busy);
        end
        n_cmp++;
        if (o_drop !== 1'b0) begin
            n_err++; $display("FAIL reset_drop: got %b want 0", o_drop);
        end
    endtask

    task automatic test_alu_pair();
        logic [7:0] want[$];
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drive(1, 16'hA55A, 0, 8'h0, 0, 8'h0, 0);
            else drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL alu_pair c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            advance();
        end
        want = '{8'h5A, 8'hA5};
        n_cmp++;
        if (wr_log != want || o_busy !== 1'b0) begin
            n_err++; $display("FAIL alu_pair_log: got %p busy=%b want %p busy=0",
                              wr_log, o_busy, want);
        end
    endtask

    task automatic test_three_sources();
        logic [7:0] want[$];
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive(1, 16'h1234, 1, 8'h77, 1, 8'hEE, 0);
            else drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL three_src c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            advance();
        end
        want = '{8'h34, 8'h12, 8'h77, 8'hEE};
        n_cmp++;
        if (wr_log != want) begin
            n_err++; $display("FAIL three_src_log: got %p want %p", wr_log, want);
        end
    endtask

    task automatic test_full_hold();
        logic [7:0] want[$];
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c == 0) drive(1, 16'h1234, 0, 8'h0, 0, 8'h0, 0);
            else drive(0, 16'h0, 0, 8'h0, 0, 8'h0, (c >= 3 && c <= 7));
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL full_hold c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            advance();
        end
        want = '{8'h34, 8'h12};
        n_cmp++;
        if (wr_log != want) begin
            n_err++; $display("FAIL full_hold_log: got %p want %p", wr_log, want);
        end
    endtask

    task automatic test_drop();
        logic [7:0] want[$];
        int         drops;
        drops = 0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            unique case (c)
                0:       drive(0, 16'h0, 1, 8'h11, 0, 8'h0, 1);
                2:       drive(0, 16'h0, 1, 8'h22, 0, 8'h0, 1);
                3:       drive(0, 16'h0, 1, 8'h33, 0, 8'h0, 1);
                1, 4:    drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 1);
                default: drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
            endcase
            if (o_drop === 1'b1) drops++;
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL drop c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            advance();
        end
        want = '{8'h11, 8'h22};
        n_cmp++;
        if (wr_log != want || drops != 1) begin
            n_err++; $display("FAIL drop_log: got %p drops=%0d want %p drops=1",
                              wr_log, drops, want);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] want[$];
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(1, 16'hA55A, 0, 8'h0, 0, 8'h0, 0);
            else drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL mid_rst c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            advance();
        end
        // High byte A5 is now on the output; cut it off.
        i_reset = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 11'h000) begin
            n_err++; $display("FAIL mid_rst_outputs: got %h want 000", dut_vec);
        end
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL mid_rst_after c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            advance();
        end
        want = '{8'h5A};
        n_cmp++;
        if (wr_log != want) begin
            n_err++; $display("FAIL mid_rst_log: got %p want %p", wr_log, want);
        end
    endtask

    task automatic test_alternate();
        logic [7:0] pat[3];
        do_reset();
        for (int c = 0; c < 32; c++) begin
            if (c < 24) drive(1, 16'hAABB, 1, 8'h11, 0, 8'h0, 0);
            else drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL alternate c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            advance();
        end
        pat = '{8'hBB, 8'hAA, 8'h11};
        n_cmp++;
        if (wr_log.size() < 12) begin
            n_err++; $display("FAIL alternate_len: got %0d want >=12", wr_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++;
                if (wr_log[i] !== pat[i % 3]) begin
                    n_err++; $display("FAIL alternate_byte%0d: got %h want %h",
                                      i, wr_log[i], pat[i % 3]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c < 580) begin
                drive(($urandom_range(0, 2) == 0), 16'($urandom),
                      ($urandom_range(0, 2) == 0), 8'($urandom),
                      ($urandom_range(0, 2) == 0), 8'($urandom),
                      ($urandom_range(0, 3) == 0));
            end else begin
                drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
            end
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL random c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            advance();
        end
    endtask

    initial begin
        i_reset = 1'b0;
        model_reset();
        drive(0, 16'h0, 0, 8'h0, 0, 8'h0, 0);
        @(negedge i_clk);
        test_reset();
        test_alu_pair();
        test_three_sources();
        test_full_hold();
        test_drop();
        test_reset_mid_frame();
        test_alternate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning FIFO byte width.
REQ-002 The block SHALL have parameter ALU_OUT_WIDTH, default 16 (2*DATA_WIDTH), meaning ALU result width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: i_clk  in  1  rising-edge system clock.
REQ-004 i_reset  in  1  asynchronous active-low reset.
REQ-005 i_alu_out  in  ALU_OUT_WIDTH  ALU result.
REQ-006 i_alu_valid  in  1  one-cycle pulse, i_alu_out valid.
REQ-007 i_rd_data  in  DATA_WIDTH  register-file read data.
REQ-008 i_rd_valid  in  1  one-cycle pulse, i_rd_data valid.
REQ-009 i_sts_data  in  DATA_WIDTH  status/error byte from controller.
REQ-010 i_sts_valid  in  1  one-cycle pulse, i_sts_data valid.
REQ-011 i_fifo_full  in  1  async-FIFO full, write-clock domain.
REQ-012 o_fifo_wr_en  out  1  FIFO write enable.
REQ-013 o_fifo_wr_data  out  DATA_WIDTH  FIFO write byte.
REQ-014 o_busy  out  1  pending request or frame in progress.
REQ-015 o_drop  out  1  one-cycle pulse, request lost.

Function
REQ-016 Each source (ALU=0, RD=1, STS=2) SHALL own a one-entry holding slot with a pending flag, loaded at the edge sampling its valid.
REQ-017 A valid arriving while its slot is pending and not granted that edge SHALL be dropped, the original slot data retained, and o_drop pulsed the next cycle.
REQ-018 A valid arriving on the edge its slot is granted SHALL be captured; the pending flag stays set.
REQ-019 FSM states SHALL be IDLE, SEND, SEND_HI.
REQ-020 IDLE: if any pending, grant per round-robin, clear that slot's pending flag, load o_fifo_wr_data, go to SEND; else stay.
REQ-021 Round-robin SHALL search from the pointer upward modulo 3; the pointer becomes granted source + 1.
REQ-022 SEND: ALU grants load the low byte (i_alu_out[7:0]) first; on acceptance, go to SEND_HI and load the high byte.
REQ-023 SEND (non-ALU) or SEND_HI: on acceptance, if any pending, grant immediately and stay in SEND; else go to IDLE.
REQ-024 Acceptance SHALL be o_fifo_wr_en high at a rising edge.
REQ-025 o_fifo_wr_en SHALL equal (state != IDLE) AND NOT i_fifo_full; it is the only combinational output.
REQ-026 While full, the state and o_fifo_wr_data SHALL hold; no byte is skipped or duplicated.
REQ-027 The two ALU bytes SHALL be written as an atomic pair; no other source interleaves.
REQ-028 Latency: valid sampled at edge k, first byte accepted at edge k+2 when not full.
REQ-029 o_busy SHALL equal (state != IDLE) OR any pending flag.

Reset
REQ-030 On i_reset low, the block SHALL set state IDLE, clear all pending flags, set the pointer to 0, and drive o_fifo_wr_data=0, o_fifo_wr_en=0, o_busy=0, o_drop=0.
REQ-031 Reset mid-frame SHALL discard the partial ALU pair; the high byte is never emitted after release.

Structure
REQ-032 arb_state_t (IDLE/SEND/SEND_HI) and src_t (SRC_ALU/SRC_RD/SRC_STS) SHALL live in myPkg.
REQ-033 Sub-module rr_arb3 SHALL hold the pointer and produce a one-hot grant from a 3-bit request vector.

Verification
REQ-034 ALU 16'hA55A, full=0 -> bytes 8'h5A then 8'hA5 on consecutive edges k+2, k+3; o_busy is 0 afterwards.
REQ-035 After reset, ALU 16'h1234, RD 8'h77 and STS 8'hEE valid in the same cycle -> writes 34,12,77,EE on four consecutive edges.
REQ-036 Full held high 5 cycles while in SEND_HI (data 12) -> wr_en low and data stable; 12 is written exactly once after full falls.
REQ-037 Full high; RD 11 sampled, then 22 sampled after 11 is granted, then 33 sampled -> 33 dropped with o_drop pulse; output sequence 11, 22.
REQ-038 Reset asserted between the 5A and A5 bytes -> outputs 0; no A5 written after release.
REQ-039 ALU and RD requesting every cycle -> grants alternate ALU-pair, RD, ALU-pair, RD.
